// File: rtl/pcie_perf_mon_if.sv
// pcie_perf_mon_if -- bundles the streaming TX, DPL buffer request/grant,
// block-done and snapshot signals observed/produced by pcie_perf_mon.
//   master : drives the observed inputs, reads the snapshot outputs
//   slave  : the monitor itself (reads inputs, drives snapshot outputs)
interface pcie_perf_mon_if #(
  parameter int PORTS       = 12,
  parameter int PORT_WIDTH  = $clog2(PORTS),
  parameter int CTR_WIDTH   = 32,
  parameter int BEAT_QW     = 4,
  parameter int EMPTY_WIDTH = $clog2(BEAT_QW)
) ();
  logic                             iST_SOP;
  logic                             iST_VAL;
  logic [EMPTY_WIDTH-1:0]           iST_EMPTY;
  logic                             iST_RDY_N;
  logic [PORTS-1:0]                 iDPLBUF_REQ;
  logic [PORTS-1:0]                 iDPLBUF_GNT;
  logic                             iBLK_DONE;
  logic [PORT_WIDTH-1:0]            iLINK_NUM;
  logic                             iLATCH;
  logic [CTR_WIDTH-1:0]             oSOP_CNT;
  logic [CTR_WIDTH-1:0]             oBYTE_CNT;
  logic [CTR_WIDTH-1:0]             oSTALL_CNT;
  logic [PORTS-1:0][CTR_WIDTH-1:0]  oDONE_CNT;
  logic [PORTS-1:0][CTR_WIDTH-1:0]  oWAIT_MAX;
  logic                             oBAD_LINK;
  logic                             oSNAP_VLD;

  modport master (
    output iST_SOP, iST_VAL, iST_EMPTY, iST_RDY_N, iDPLBUF_REQ, iDPLBUF_GNT,
           iBLK_DONE, iLINK_NUM, iLATCH,
    input  oSOP_CNT, oBYTE_CNT, oSTALL_CNT, oDONE_CNT, oWAIT_MAX, oBAD_LINK,
           oSNAP_VLD
  );

  modport slave (
    input  iST_SOP, iST_VAL, iST_EMPTY, iST_RDY_N, iDPLBUF_REQ, iDPLBUF_GNT,
           iBLK_DONE, iLINK_NUM, iLATCH,
    output oSOP_CNT, oBYTE_CNT, oSTALL_CNT, oDONE_CNT, oWAIT_MAX, oBAD_LINK,
           oSNAP_VLD
  );
endinterface

// File: rtl/pcie_perf_mon.sv
// pcie_perf_mon -- interval performance monitor for the PCIe streaming TX
// path and the DPL buffer request/grant channels.
// Live accumulators count SOPs, payload bytes, stall cycles, per-port block
// completions and per-port worst request-to-grant wait. iLATCH copies the
// live values (as they stood before that cycle) into snapshot registers,
// which drive the outputs, and restarts the live values with that cycle's
// events only. All counters saturate at all-ones.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pcie_perf_mon_if slave (observed inputs, snapshot outputs)
module pcie_perf_mon #(
  parameter int PORTS       = 12,
  parameter int PORT_WIDTH  = $clog2(PORTS),
  parameter int CTR_WIDTH   = 32,
  parameter int BEAT_QW     = 4,
  parameter int EMPTY_WIDTH = $clog2(BEAT_QW)
) (
  input  logic               clk,
  input  logic               rst_n,
  pcie_perf_mon_if.slave     bus
);

  localparam int BW = CTR_WIDTH + 1;

  typedef logic [CTR_WIDTH-1:0] ctr_t;

  function automatic ctr_t sat_inc(input ctr_t v, input logic en);
    return (en && (v != '1)) ? v + ctr_t'(1) : v;
  endfunction

  ctr_t                    sop_q, sop_d, byte_q, byte_d, stall_q, stall_d;
  logic [PORTS-1:0][CTR_WIDTH-1:0] done_q, done_d, wmax_q, wmax_d, w_q, w_d;
  logic                    bad_q, bad_d;

  ctr_t                    snap_sop_q, snap_sop_d, snap_byte_q, snap_byte_d;
  ctr_t                    snap_stall_q, snap_stall_d;
  logic [PORTS-1:0][CTR_WIDTH-1:0] snap_done_q, snap_done_d;
  logic [PORTS-1:0][CTR_WIDTH-1:0] snap_wmax_q, snap_wmax_d;
  logic                    snap_bad_q, snap_bad_d, snap_vld_q, snap_vld_d;

  logic                    latch;
  logic                    link_bad;
  logic [BW-1:0]           byte_inc, byte_sum;

  always_comb begin
    latch    = bus.iLATCH;
    link_bad = 32'(bus.iLINK_NUM) >= PORTS;

    // Live values restart from zero on a latch cycle, then take this cycle's events.
    sop_d    = sat_inc(latch ? '0 : sop_q, bus.iST_SOP & bus.iST_VAL);
    stall_d  = sat_inc(latch ? '0 : stall_q, bus.iST_RDY_N);

    byte_inc = bus.iST_VAL ? ((BW'(BEAT_QW) - BW'(bus.iST_EMPTY)) << 3) : '0;
    byte_sum = {1'b0, (latch ? ctr_t'('0) : byte_q)} + byte_inc;
    byte_d   = byte_sum[CTR_WIDTH] ? '1 : byte_sum[CTR_WIDTH-1:0];

    bad_d    = (latch ? 1'b0 : bad_q) | (bus.iBLK_DONE & link_bad);

    for (int unsigned i = 0; i < PORTS; i++) begin
      done_d[i] = sat_inc(latch ? '0 : done_q[i],
                          bus.iBLK_DONE && !link_bad && (32'(bus.iLINK_NUM) == i));

      // The wait counter runs across latches; its value at grant time is
      // charged to whichever interval the grant falls in.
      wmax_d[i] = latch ? '0 : wmax_q[i];
      if (bus.iDPLBUF_REQ[i] && bus.iDPLBUF_GNT[i] && (w_q[i] > wmax_d[i]))
        wmax_d[i] = w_q[i];

      if (!bus.iDPLBUF_REQ[i] || bus.iDPLBUF_GNT[i]) w_d[i] = '0;
      else                                           w_d[i] = sat_inc(w_q[i], 1'b1);
    end

    snap_sop_d   = latch ? sop_q   : snap_sop_q;
    snap_byte_d  = latch ? byte_q  : snap_byte_q;
    snap_stall_d = latch ? stall_q : snap_stall_q;
    snap_done_d  = latch ? done_q  : snap_done_q;
    snap_wmax_d  = latch ? wmax_q  : snap_wmax_q;
    snap_bad_d   = latch ? bad_q   : snap_bad_q;
    snap_vld_d   = latch;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sop_q        <= '0;
      byte_q       <= '0;
      stall_q      <= '0;
      done_q       <= '0;
      wmax_q       <= '0;
      w_q          <= '0;
      bad_q        <= 1'b0;
      snap_sop_q   <= '0;
      snap_byte_q  <= '0;
      snap_stall_q <= '0;
      snap_done_q  <= '0;
      snap_wmax_q  <= '0;
      snap_bad_q   <= 1'b0;
      snap_vld_q   <= 1'b0;
    end else begin
      sop_q        <= sop_d;
      byte_q       <= byte_d;
      stall_q      <= stall_d;
      done_q       <= done_d;
      wmax_q       <= wmax_d;
      w_q          <= w_d;
      bad_q        <= bad_d;
      snap_sop_q   <= snap_sop_d;
      snap_byte_q  <= snap_byte_d;
      snap_stall_q <= snap_stall_d;
      snap_done_q  <= snap_done_d;
      snap_wmax_q  <= snap_wmax_d;
      snap_bad_q   <= snap_bad_d;
      snap_vld_q   <= snap_vld_d;
    end
  end

  assign bus.oSOP_CNT   = snap_sop_q;
  assign bus.oBYTE_CNT  = snap_byte_q;
  assign bus.oSTALL_CNT = snap_stall_q;
  assign bus.oDONE_CNT  = snap_done_q;
  assign bus.oWAIT_MAX  = snap_wmax_q;
  assign bus.oBAD_LINK  = snap_bad_q;
  assign bus.oSNAP_VLD  = snap_vld_q;

endmodule

// File: tb/tb_pcie_perf_mon.sv
module tb_pcie_perf_mon;
  localparam int PORTS = 12;
  localparam int PW    = $clog2(PORTS);
  localparam int CW    = 16;
  localparam int BQ    = 4;
  localparam int EW    = $clog2(BQ);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pcie_perf_mon_if #(.PORTS(PORTS), .PORT_WIDTH(PW), .CTR_WIDTH(CW),
                     .BEAT_QW(BQ), .EMPTY_WIDTH(EW)) bus ();

  pcie_perf_mon #(.PORTS(PORTS), .PORT_WIDTH(PW), .CTR_WIDTH(CW),
                  .BEAT_QW(BQ), .EMPTY_WIDTH(EW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic          sop;
    logic          val;
    logic [EW-1:0] empty;
    logic          rdy_n;
    logic          latch;
    logic          e_vld;
    logic [CW-1:0] e_sop;
    logic [CW-1:0] e_byte;
    logic [CW-1:0] e_stall;
  } vec_t;

  vec_t vecs [11];
  int checks   = 0;
  int failures = 0;
  logic [PORTS-1:0][CW-1:0] exp_p;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iST_SOP     = 1'b0;
    bus.iST_VAL     = 1'b0;
    bus.iST_EMPTY   = '0;
    bus.iST_RDY_N   = 1'b0;
    bus.iDPLBUF_REQ = '0;
    bus.iDPLBUF_GNT = '0;
    bus.iBLK_DONE   = 1'b0;
    bus.iLINK_NUM   = '0;
    bus.iLATCH      = 1'b0;
  endtask

  task automatic chk_wait(input string tag, input logic [PORTS-1:0][CW-1:0] e);
    for (int i = 0; i < PORTS; i++)
      chk($sformatf("%s_wait_max[%0d]", tag, i), bus.oWAIT_MAX[i], e[i]);
  endtask

  task automatic chk_done(input string tag, input logic [PORTS-1:0][CW-1:0] e);
    for (int i = 0; i < PORTS; i++)
      chk($sformatf("%s_done[%0d]", tag, i), bus.oDONE_CNT[i], e[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          sop val emp rdy lat | vld  sop  byte stall
    vecs[0]  = '{1, 1, 0, 0, 0, 0, 0,  0, 0};
    vecs[1]  = '{0, 1, 1, 0, 0, 0, 0,  0, 0};
    vecs[2]  = '{0, 1, 2, 0, 0, 0, 0,  0, 0};
    vecs[3]  = '{0, 1, 3, 0, 0, 0, 0,  0, 0};
    vecs[4]  = '{0, 0, 0, 0, 1, 1, 1, 80, 0};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 1, 80, 0};
    vecs[6]  = '{0, 1, 0, 1, 0, 0, 1, 80, 0};
    vecs[7]  = '{1, 0, 0, 1, 0, 0, 1, 80, 0};
    vecs[8]  = '{1, 1, 3, 1, 1, 1, 0, 32, 2};
    vecs[9]  = '{0, 0, 0, 0, 1, 1, 1,  8, 1};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 1,  8, 1};

    // Reset with activity that must be ignored
    rst_n = 1'b0;
    idle();
    bus.iLATCH = 1'b1; bus.iST_VAL = 1'b1; bus.iST_SOP = 1'b1; bus.iST_RDY_N = 1'b1;
    repeat (3) cyc();
    idle();
    rst_n = 1'b1;
    chk("rst_sop", bus.oSOP_CNT, 0);
    chk("rst_byte", bus.oBYTE_CNT, 0);
    chk("rst_vld", bus.oSNAP_VLD, 0);
    chk("rst_bad", bus.oBAD_LINK, 0);
    cyc();
    chk("post_rst_vld", bus.oSNAP_VLD, 0);

    // Streaming vectors
    for (int v = 0; v < 11; v++) begin
      bus.iST_SOP   = vecs[v].sop;
      bus.iST_VAL   = vecs[v].val;
      bus.iST_EMPTY = vecs[v].empty;
      bus.iST_RDY_N = vecs[v].rdy_n;
      bus.iLATCH    = vecs[v].latch;
      cyc();
      chk($sformatf("v%0d_vld", v),   bus.oSNAP_VLD,  vecs[v].e_vld);
      chk($sformatf("v%0d_sop", v),   bus.oSOP_CNT,   vecs[v].e_sop);
      chk($sformatf("v%0d_byte", v),  bus.oBYTE_CNT,  vecs[v].e_byte);
      chk($sformatf("v%0d_stall", v), bus.oSTALL_CNT, vecs[v].e_stall);
    end
    idle();

    // SOP coincident with latch belongs to the next interval
    bus.iST_SOP = 1'b1; bus.iST_VAL = 1'b1;
    cyc();
    bus.iLATCH = 1'b1;
    cyc();
    chk("lsop_first_sop", bus.oSOP_CNT, 1);
    chk("lsop_first_byte", bus.oBYTE_CNT, 32);
    idle();
    for (int c = 0; c < 9; c++) begin
      cyc();
      if (c == 4) begin
        chk("lsop_mid_vld", bus.oSNAP_VLD, 0);
        chk("lsop_mid_sop", bus.oSOP_CNT, 1);
      end
    end
    bus.iLATCH = 1'b1;
    cyc();
    chk("lsop_second_vld", bus.oSNAP_VLD, 1);
    chk("lsop_second_sop", bus.oSOP_CNT, 1);
    chk("lsop_second_byte", bus.oBYTE_CNT, 32);
    idle();

    // Request-to-grant waits
    for (int c = 1; c <= 6; c++) begin
      bus.iDPLBUF_REQ = '0; bus.iDPLBUF_GNT = '0;
      bus.iDPLBUF_REQ[3] = 1'b1;
      if (c == 6) begin
        bus.iDPLBUF_GNT[3] = 1'b1;
        bus.iDPLBUF_REQ[0] = 1'b1; bus.iDPLBUF_GNT[0] = 1'b1;
      end
      if (c <= 2) bus.iDPLBUF_REQ[1] = 1'b1;
      if (c == 3) bus.iDPLBUF_GNT[1] = 1'b1;
      if (c == 4) bus.iDPLBUF_GNT[5] = 1'b1;
      cyc();
    end
    idle();
    bus.iLATCH = 1'b1;
    cyc();
    chk("wait1_vld", bus.oSNAP_VLD, 1);
    exp_p = '0; exp_p[3] = 5;
    chk_wait("wait1", exp_p);
    idle();

    // Wait spanning a latch boundary, and a smaller later wait not lowering max
    for (int c = 1; c <= 9; c++) begin
      bus.iDPLBUF_REQ = '0; bus.iDPLBUF_GNT = '0; bus.iLATCH = 1'b0;
      if (c <= 5) bus.iDPLBUF_REQ[4] = 1'b1;
      if (c == 5) bus.iDPLBUF_GNT[4] = 1'b1;
      if (c >= 5 && c <= 8) bus.iDPLBUF_REQ[3] = 1'b1;
      if (c >= 7 && c <= 8) bus.iDPLBUF_GNT[3] = 1'b1;
      if (c == 4 || c == 9) bus.iLATCH = 1'b1;
      cyc();
      if (c == 4) begin
        exp_p = '0;
        chk_wait("wait2a", exp_p);
      end
    end
    exp_p = '0; exp_p[4] = 4; exp_p[3] = 2;
    chk_wait("wait2b", exp_p);
    idle();

    // Block done and bad link
    for (int c = 0; c < 5; c++) begin
      bus.iBLK_DONE = 1'b1;
      case (c)
        2:       bus.iLINK_NUM = PW'(PORTS);
        4:       bus.iLINK_NUM = PW'(PORTS - 1);
        default: bus.iLINK_NUM = PW'(2);
      endcase
      cyc();
    end
    idle();
    bus.iLATCH = 1'b1;
    cyc();
    chk("done1_bad", bus.oBAD_LINK, 1);
    exp_p = '0; exp_p[2] = 3; exp_p[PORTS-1] = 1;
    chk_done("done1", exp_p);
    cyc();
    chk("done2_bad", bus.oBAD_LINK, 0);
    chk("done2_done2", bus.oDONE_CNT[2], 0);
    idle();

    // Stall saturation
    bus.iST_RDY_N = 1'b1;
    repeat (70000) cyc();
    bus.iST_RDY_N = 1'b0;
    bus.iLATCH = 1'b1;
    cyc();
    chk("sat_vld", bus.oSNAP_VLD, 1);
    chk("sat_stall", bus.oSTALL_CNT, 16'hFFFF);
    idle();

    // Asynchronous reset mid-interval
    bus.iST_SOP = 1'b1; bus.iST_VAL = 1'b1; bus.iBLK_DONE = 1'b1;
    bus.iLINK_NUM = PW'(2); bus.iDPLBUF_REQ[3] = 1'b1;
    cyc();
    idle();
    bus.iDPLBUF_REQ[3] = 1'b1; bus.iDPLBUF_GNT[3] = 1'b1;
    cyc();
    idle();
    bus.iLATCH = 1'b1; bus.iST_SOP = 1'b1; bus.iST_VAL = 1'b1;
    cyc();
    chk("pre_rst_sop", bus.oSOP_CNT, 1);
    chk("pre_rst_wait3", bus.oWAIT_MAX[3], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sop", bus.oSOP_CNT, 0);
    chk("arst_byte", bus.oBYTE_CNT, 0);
    chk("arst_done2", bus.oDONE_CNT[2], 0);
    chk("arst_wait3", bus.oWAIT_MAX[3], 0);
    chk("arst_vld", bus.oSNAP_VLD, 0);
    repeat (2) cyc();
    idle();
    rst_n = 1'b1;
    bus.iLATCH = 1'b1;
    cyc();
    chk("after_rst_vld", bus.oSNAP_VLD, 1);
    chk("after_rst_sop", bus.oSOP_CNT, 0);
    chk("after_rst_byte", bus.oBYTE_CNT, 0);
    chk("after_rst_stall", bus.oSTALL_CNT, 0);
    chk("after_rst_bad", bus.oBAD_LINK, 0);
    idle();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
